// File: rtl/load_store_ctrl.sv
// Queues execute-stage memory ops and sequences them onto a single-port data bus, one op in flight.
// Stores need two cycles with a zero-wait grant; load writeback is a 1-cycle pulse the cycle after rvalid.
module load_store_ctrl #(
   parameter int cXLEN       = 32,
   parameter int cRegSelBitW = 5,
   parameter int cDepth      = 4
) (
   input  logic                   iClk,
   input  logic                   iRst,
   input  logic                   iOpDv,
   input  logic                   iOpRead,
   input  logic                   iOpWrite,
   input  logic [cXLEN-1:0]       iOpAddr,
   input  logic [cXLEN-1:0]       iOpData,
   input  logic [2:0]             iOpType,
   input  logic [cRegSelBitW-1:0] iOpRdAddr,
   output logic                   oOpStall,
   output logic                   oMemReq,
   output logic                   oMemWe,
   output logic [cXLEN-1:0]       oMemAddr,
   output logic [cXLEN-1:0]       oMemWData,
   output logic [3:0]             oMemBe,
   input  logic                   iMemGnt,
   input  logic                   iMemRValid,
   input  logic [cXLEN-1:0]       iMemRData,
   output logic                   oRegDv,
   output logic [cRegSelBitW-1:0] oRegAddr,
   output logic [cXLEN-1:0]       oRegData,
   output logic                   oMemErr,
   output logic                   oBusy
);

   localparam int cPtrW = $clog2(cDepth);
   localparam int cCntW = cPtrW + 1;

   typedef enum logic [1:0] {
      sIdle    = 2'd0,
      sReq     = 2'd1,
      sWaitRsp = 2'd2
   } state_t;

   typedef struct packed {
      logic                   read;
      logic [cXLEN-1:0]       addr;
      logic [cXLEN-1:0]       data;
      logic [2:0]             ftype;
      logic [cRegSelBitW-1:0] rd;
   } op_t;

   op_t                    q_mem [cDepth];
   logic [cPtrW-1:0]       wr_ptr;
   logic [cPtrW-1:0]       rd_ptr;
   logic [cCntW-1:0]       count;
   logic [cCntW-1:0]       count_nxt;
   logic                   stall;
   logic                   push;
   logic                   pop;
   op_t                    head;

   logic [1:0]             head_size;
   logic [1:0]             head_off;
   logic                   funct_bad;
   logic                   misaligned;
   logic                   head_illegal;
   logic [3:0]             head_be;
   logic [cXLEN-1:0]       head_wdata;

   state_t                 state;
   state_t                 state_nxt;

   logic                   iss_we;
   logic [cXLEN-1:0]       iss_addr;
   logic [cXLEN-1:0]       iss_wdata;
   logic [3:0]             iss_be;
   logic [2:0]             iss_ftype;
   logic [1:0]             iss_off;
   logic [cRegSelBitW-1:0] iss_rd;

   logic                   err;
   logic                   reg_dv;
   logic [cRegSelBitW-1:0] reg_addr;
   logic [cXLEN-1:0]       reg_data;
   logic [cXLEN-1:0]       rsp_shifted;
   logic [cXLEN-1:0]       load_val;
   logic                   rsp_take;

   assign push      = iOpDv & (iOpRead ^ iOpWrite) & ~stall;
   assign pop       = (state == sIdle) & (count != '0);
   assign head      = q_mem[rd_ptr];
   assign count_nxt = count + cCntW'(push) - cCntW'(pop);
   assign rsp_take  = (state == sWaitRsp) & iMemRValid;

   always_ff @(posedge iClk) begin
      if (push) begin
         q_mem[wr_ptr] <= {iOpRead, iOpAddr, iOpData, iOpType, iOpRdAddr};
      end
   end

   // Stall is the registered full flag, so a pop in the same cycle never frees a slot for a push.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         stall  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         stall <= (count_nxt == cCntW'(cDepth));
      end
   end

   always_comb begin
      head_size = head.ftype[1:0];
      head_off  = head.addr[1:0];
      if (head.read) begin
         funct_bad = (head.ftype == 3'b011) || (head.ftype[2:1] == 2'b11);
      end else begin
         funct_bad = (head.ftype >= 3'b011);
      end
      misaligned   = ((head_size == 2'd1) && head_off[0]) ||
                     ((head_size == 2'd2) && (head_off != 2'd0));
      head_illegal = funct_bad | misaligned;

      case (head_size)
         2'd0:    head_be = 4'b0001 << head_off;
         2'd1:    head_be = 4'b0011 << head_off;
         default: head_be = 4'b1111;
      endcase

      case (head_size)
         2'd0:    head_wdata = {4{head.data[7:0]}};
         2'd1:    head_wdata = {2{head.data[15:0]}};
         default: head_wdata = head.data;
      endcase
   end

   always_comb begin
      rsp_shifted = iMemRData >> {iss_off, 3'b000};
      case (iss_ftype)
         3'b000:  load_val = {{(cXLEN-8){rsp_shifted[7]}}, rsp_shifted[7:0]};
         3'b100:  load_val = {{(cXLEN-8){1'b0}}, rsp_shifted[7:0]};
         3'b001:  load_val = {{(cXLEN-16){rsp_shifted[15]}}, rsp_shifted[15:0]};
         3'b101:  load_val = {{(cXLEN-16){1'b0}}, rsp_shifted[15:0]};
         default: load_val = iMemRData;
      endcase
   end

   // FSM state register
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state <= sIdle;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         sIdle: begin
            if (pop && !head_illegal) state_nxt = sReq;
         end
         sReq: begin
            if (iMemGnt) state_nxt = iss_we ? sIdle : sWaitRsp;
         end
         sWaitRsp: begin
            if (iMemRValid) state_nxt = sIdle;
         end
         default: state_nxt = sIdle;
      endcase
   end

   // FSM outputs: bus fields only driven while requesting
   always_comb begin
      oMemReq   = (state == sReq);
      oMemWe    = oMemReq & iss_we;
      oMemAddr  = oMemReq ? iss_addr  : '0;
      oMemWData = oMemReq ? iss_wdata : '0;
      oMemBe    = oMemReq ? iss_be    : 4'b0000;
      oBusy     = (count != '0) | (state != sIdle);
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         iss_we    <= 1'b0;
         iss_addr  <= '0;
         iss_wdata <= '0;
         iss_be    <= 4'b0000;
         iss_ftype <= 3'b000;
         iss_off   <= 2'b00;
         iss_rd    <= '0;
         err       <= 1'b0;
         reg_dv    <= 1'b0;
         reg_addr  <= '0;
         reg_data  <= '0;
      end else begin
         err    <= pop & head_illegal;
         reg_dv <= rsp_take & (iss_rd != '0);
         if (pop && !head_illegal) begin
            iss_we    <= ~head.read;
            iss_addr  <= {head.addr[cXLEN-1:2], 2'b00};
            iss_wdata <= head_wdata;
            iss_be    <= head_be;
            iss_ftype <= head.ftype;
            iss_off   <= head_off;
            iss_rd    <= head.rd;
         end
         if (rsp_take) begin
            reg_addr <= iss_rd;
            reg_data <= load_val;
         end
      end
   end

   assign oOpStall = stall;
   assign oMemErr  = err;
   assign oRegDv   = reg_dv;
   assign oRegAddr = reg_addr;
   assign oRegData = reg_data;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Bench for load_store_ctrl: directed scenarios with literal expectations plus a random run
// scored against a transaction-level model (op queue, legality rules, lane arithmetic).
module tb_load_store_ctrl;

   logic        iClk, iRst;
   logic        iOpDv, iOpRead, iOpWrite;
   logic [31:0] iOpAddr, iOpData;
   logic [2:0]  iOpType;
   logic [4:0]  iOpRdAddr;
   logic        oOpStall, oMemReq, oMemWe;
   logic [31:0] oMemAddr, oMemWData;
   logic [3:0]  oMemBe;
   logic        iMemGnt, iMemRValid;
   logic [31:0] iMemRData;
   logic        oRegDv;
   logic [4:0]  oRegAddr;
   logic [31:0] oRegData;
   logic        oMemErr, oBusy;

   load_store_ctrl #(.cXLEN(32), .cRegSelBitW(5), .cDepth(4)) dut (
      .iClk(iClk), .iRst(iRst),
      .iOpDv(iOpDv), .iOpRead(iOpRead), .iOpWrite(iOpWrite),
      .iOpAddr(iOpAddr), .iOpData(iOpData), .iOpType(iOpType), .iOpRdAddr(iOpRdAddr),
      .oOpStall(oOpStall), .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
      .oMemWData(oMemWData), .oMemBe(oMemBe), .iMemGnt(iMemGnt), .iMemRValid(iMemRValid),
      .iMemRData(iMemRData), .oRegDv(oRegDv), .oRegAddr(oRegAddr), .oRegData(oRegData),
      .oMemErr(oMemErr), .oBusy(oBusy)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   typedef struct {
      bit          is_load;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  f;
      logic [4:0]  rd;
   } mop_t;

   int tests, fails;
   int n_gnt, n_err, n_wb, n_reqcyc;
   logic [31:0] g_addr, g_wdata, last_wb_data;
   logic [3:0]  g_be;
   logic        g_we;
   logic [4:0]  last_wb_addr;

   mop_t        mq[$];
   mop_t        cur;
   bit          pending, wb_exp, prev_req, prev_gnt;
   logic [31:0] wb_d;
   logic [4:0]  wb_a;

   int          gnt_mode, rv_mode;
   logic [31:0] rdata_val;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic bit legal(mop_t op);
      int sz;
      sz = int'(op.f) % 4;
      if (op.is_load) begin
         if (!(op.f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
      end else if (op.f > 3'd2) begin
         return 1'b0;
      end
      if (sz == 1 && (op.addr % 2) != 0) return 1'b0;
      if (sz == 2 && (op.addr % 4) != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [3:0] exp_be(mop_t op);
      int o;
      o = int'(op.addr % 4);
      case (int'(op.f) % 4)
         0:       return 4'(1 << o);
         1:       return 4'(3 << o);
         default: return 4'd15;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(mop_t op);
      case (int'(op.f) % 4)
         0:       return (op.data & 32'hFF) * 32'h0101_0101;
         1:       return (op.data & 32'hFFFF) * 32'h0001_0001;
         default: return op.data;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(mop_t op, logic [31:0] rdata);
      logic [31:0] w, b, h;
      w = rdata >> (8 * int'(op.addr % 4));
      b = w & 32'hFF;
      h = w & 32'hFFFF;
      case (op.f)
         3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
         3'd5:    return h;
         default: return rdata;
      endcase
   endfunction

   // Memory responder: gnt/rvalid policy chosen by the stimulus
   always @(posedge iClk) begin
      #1;
      case (gnt_mode)
         0:       iMemGnt = 1'b0;
         1:       iMemGnt = 1'b1;
         default: iMemGnt = 1'($urandom % 2);
      endcase
      case (rv_mode)
         0:       iMemRValid = 1'b0;
         1:       iMemRValid = 1'b1;
         default: iMemRValid = 1'($urandom % 2);
      endcase
      iMemRData = (rv_mode == 2) ? $urandom : rdata_val;
   end

   // Compare process: check outputs, then advance the model across the coming edge
   always @(negedge iClk) begin
      mop_t op;
      bit   new_issue;
      if (iRst) begin
         chk("reset_outputs", 32'({oOpStall, oMemReq, oMemWe, oMemBe, oRegDv, oMemErr, oBusy,
             |oMemAddr, |oMemWData, |oRegAddr, |oRegData}), 32'd0);
         mq.delete();
         pending  = 0;
         wb_exp   = 0;
         prev_req = 0;
         prev_gnt = 0;
      end else begin
         new_issue = oMemReq && (!prev_req || prev_gnt);
         if (oMemReq) n_reqcyc++;
         chk("err_wb_exclusive", 32'(oMemErr & oRegDv), 32'd0);
         if (oMemErr) begin
            n_err++;
            if (mq.size() == 0) chk("err_with_empty_queue", 32'(mq.size()), 32'd1);
            else begin
               op = mq.pop_front();
               chk("err_op_is_illegal", 32'(legal(op)), 32'd0);
            end
         end
         if (new_issue) begin
            if (mq.size() == 0) chk("issue_with_empty_queue", 32'(mq.size()), 32'd1);
            else begin
               op = mq.pop_front();
               chk("issued_op_is_legal", 32'(legal(op)), 32'd1);
               cur = op;
            end
         end
         if (oMemReq) begin
            chk("req_we", 32'(oMemWe), 32'(!cur.is_load));
            chk("req_addr", oMemAddr, cur.addr & ~32'd3);
            chk("req_be", 32'(oMemBe), 32'(exp_be(cur)));
            if (!cur.is_load) chk("req_wdata", oMemWData, exp_wdata(cur));
         end
         if (wb_exp) begin
            chk("wb_valid", 32'(oRegDv), 32'd1);
            chk("wb_addr", 32'(oRegAddr), 32'(wb_a));
            chk("wb_data", oRegData, wb_d);
         end else begin
            chk("no_spurious_wb", 32'(oRegDv), 32'd0);
         end
         if (oRegDv) begin
            n_wb++;
            last_wb_data = oRegData;
            last_wb_addr = oRegAddr;
         end
         chk("stall", 32'(oOpStall), 32'(mq.size() == 4));
         chk("busy", 32'(oBusy), 32'((mq.size() != 0) || oMemReq || pending));

         wb_exp = 0;
         if (pending && iMemRValid) begin
            pending = 0;
            if (cur.rd != 0) begin
               wb_exp = 1;
               wb_d   = exp_load(cur, iMemRData);
               wb_a   = cur.rd;
            end
         end
         prev_gnt = oMemReq && iMemGnt;
         if (prev_gnt) begin
            n_gnt++;
            g_addr  = oMemAddr;
            g_be    = oMemBe;
            g_wdata = oMemWData;
            g_we    = oMemWe;
            if (cur.is_load) pending = 1;
         end
         prev_req = oMemReq;
         if (iOpDv && (iOpRead ^ iOpWrite) && !oOpStall) begin
            op.is_load = iOpRead;
            op.addr    = iOpAddr;
            op.data    = iOpData;
            op.f       = iOpType;
            op.rd      = iOpRdAddr;
            mq.push_back(op);
         end
      end
   end

   // All helpers start and end 2 time units after a rising edge
   task automatic push_op(input bit ld, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, input logic [4:0] rd);
      bit acc;
      acc       = 0;
      iOpDv     = 1'b1;
      iOpRead   = ld;
      iOpWrite  = !ld;
      iOpAddr   = a;
      iOpData   = d;
      iOpType   = f;
      iOpRdAddr = rd;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge iClk); #1;
         acc = !oOpStall;
         @(posedge iClk); #2;
      end
      if (!acc) begin
         tests++; fails++;
         $display("FAIL push_timeout: op at %h never accepted", a);
      end
      iOpDv = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      bit idle;
      idle = 0;
      for (int i = 0; i < max_cyc && !idle; i++) begin
         @(negedge iClk); #1;
         idle = !oBusy;
         @(posedge iClk); #2;
      end
      if (!idle) begin
         tests++; fails++;
         $display("FAIL idle_timeout: still busy after %0d cycles", max_cyc);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge iClk);
      #2;
   endtask

   int base_gnt, base_err, base_wb, base_req;

   task automatic snap();
      base_gnt = n_gnt; base_err = n_err; base_wb = n_wb; base_req = n_reqcyc;
   endtask

   initial begin
      iRst = 0; iOpDv = 0; iOpRead = 0; iOpWrite = 0; iOpAddr = 0; iOpData = 0;
      iOpType = 0; iOpRdAddr = 0; iMemGnt = 0; iMemRValid = 0; iMemRData = 0;
      gnt_mode = 1; rv_mode = 1; rdata_val = 0;
      tests = 0; fails = 0; n_gnt = 0; n_err = 0; n_wb = 0; n_reqcyc = 0;
      #1 iRst = 1;
      repeat (3) @(posedge iClk);
      #2 iRst = 0;
      chk("post_reset_busy", 32'(oBusy), 32'd0);
      chk("post_reset_stall", 32'(oOpStall), 32'd0);

      // SW, zero-wait grant
      snap();
      push_op(0, 32'h100, 32'hDEAD_BEEF, 3'd2, 5'd0);
      wait_idle(50);
      chk("sw_addr", g_addr, 32'h100);
      chk("sw_be", 32'(g_be), 32'hF);
      chk("sw_wdata", g_wdata, 32'hDEAD_BEEF);
      chk("sw_we", 32'(g_we), 32'd1);
      chk("sw_req_cycles", 32'(n_reqcyc - base_req), 32'd1);
      chk("sw_no_wb", 32'(n_wb - base_wb), 32'd0);

      // LB / LBU at byte 3
      rdata_val = 32'h8000_0000;
      push_op(1, 32'h103, 32'h0, 3'd0, 5'd5);
      wait_idle(50);
      chk("lb_addr", g_addr, 32'h100);
      chk("lb_be", 32'(g_be), 32'h8);
      chk("lb_rd", 32'(last_wb_addr), 32'd5);
      chk("lb_data", last_wb_data, 32'hFFFF_FF80);
      push_op(1, 32'h103, 32'h0, 3'd4, 5'd5);
      wait_idle(50);
      chk("lbu_data", last_wb_data, 32'h0000_0080);

      // SH / LHU at upper half
      push_op(0, 32'h202, 32'h1234_ABCD, 3'd1, 5'd0);
      wait_idle(50);
      chk("sh_addr", g_addr, 32'h200);
      chk("sh_be", 32'(g_be), 32'hC);
      chk("sh_wdata", g_wdata, 32'hABCD_ABCD);
      rdata_val = 32'h8765_0000;
      push_op(1, 32'h202, 32'h0, 3'd5, 5'd9);
      wait_idle(50);
      chk("lhu_data", last_wb_data, 32'h0000_8765);

      // Misaligned LW dropped, following SW issued
      snap();
      push_op(1, 32'h101, 32'h0, 3'd2, 5'd3);
      push_op(0, 32'h104, 32'h5555_AAAA, 3'd2, 5'd0);
      wait_idle(50);
      chk("misalign_err_count", 32'(n_err - base_err), 32'd1);
      chk("misalign_gnt_count", 32'(n_gnt - base_gnt), 32'd1);
      chk("after_err_addr", g_addr, 32'h104);

      // Backpressure: gnt held low, queue fills
      gnt_mode = 0;
      cycles(1);
      snap();
      for (int i = 0; i < 5; i++) push_op(0, 32'h400 + 32'(4 * i), 32'(i), 3'd2, 5'd0);
      iOpDv = 1; iOpRead = 0; iOpWrite = 1; iOpAddr = 32'h414; iOpData = 32'd5; iOpType = 3'd2;
      cycles(3);
      chk("full_stall", 32'(oOpStall), 32'd1);
      chk("full_no_gnt", 32'(n_gnt - base_gnt), 32'd0);
      gnt_mode = 1;
      push_op(0, 32'h414, 32'd5, 3'd2, 5'd0);
      wait_idle(100);
      chk("drain_gnt_count", 32'(n_gnt - base_gnt), 32'd6);
      chk("drain_last_addr", g_addr, 32'h414);

      // Reset while a load waits for its response
      rv_mode = 0;
      snap();
      push_op(1, 32'h300, 32'h0, 3'd2, 5'd7);
      for (int i = 0; i < 50 && n_gnt == base_gnt; i++) cycles(1);
      chk("load_granted", 32'(n_gnt - base_gnt), 32'd1);
      iRst = 1;
      #1;
      chk("async_reset_outputs", 32'({oMemReq, oBusy, oRegDv, oMemErr, oOpStall}), 32'd0);
      cycles(2);
      iRst = 0;
      rv_mode = 1;
      cycles(4);
      chk("late_rvalid_ignored", 32'(n_wb - base_wb), 32'd0);
      rdata_val = 32'h1122_3344;
      push_op(1, 32'h300, 32'h0, 3'd2, 5'd7);
      wait_idle(50);
      chk("post_reset_wb_count", 32'(n_wb - base_wb), 32'd1);
      chk("post_reset_wb_data", last_wb_data, 32'h1122_3344);

      // Random traffic against the model
      gnt_mode = 2;
      rv_mode = 2;
      for (int c = 0; c < 3000; c++) begin
         int sel;
         sel       = int'($urandom % 8);
         iOpDv     = 1'($urandom % 2);
         iOpRead   = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : 1'($urandom % 2);
         iOpWrite  = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : !iOpRead;
         iOpAddr   = {20'h0, 8'($urandom), 4'($urandom)};
         iOpData   = $urandom;
         iOpType   = 3'($urandom_range(0, 7));
         iOpRdAddr = 5'($urandom_range(0, 3));
         cycles(1);
      end
      iOpDv = 0;
      wait_idle(500);
      chk("random_queue_drained", 32'(mq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
